// File: rtl/irq_pending_ctrl.sv
// Interrupt request front end: edge-detects eight request lines into sticky pending bits,
// exposes the masked vector to an external 8:3 priority encoder and hands the winner out.
module irq_pending_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  output logic [7:0] pend_out,
  input  logic [2:0] enc_code,
  input  logic       enc_v,
  output logic       irq_valid,
  output logic [2:0] irq_code,
  input  logic       irq_ack,
  output logic [7:0] drop_cnt
);

  typedef enum logic {StIdle, StHold} state_e;

  state_e     state_q, state_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] drop_q, drop_d;
  logic       valid_q, valid_d;
  logic [2:0] code_q, code_d;

  logic [7:0] rise;
  logic [7:0] clr_vec;
  logic       ack_fire;
  logic       drop_hit;

  always_comb begin
    rise     = req_in & ~req_q;
    req_d    = req_in;
    ack_fire = (state_q == StHold) && irq_ack;

    clr_vec = 8'h00;
    if (ack_fire) begin
      clr_vec[code_q] = 1'b1;
    end
    // A rise on the bit being acknowledged re-arms it: set wins over clear.
    pend_d = (pend_q & ~clr_vec) | rise;

    // Compared against pend_q, so a bit freed by this cycle's ack still counts as occupied.
    drop_hit = |(rise & pend_q);
    drop_d   = drop_q;
    if (drop_hit && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (enc_v) begin
          code_d  = enc_code;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (irq_ack) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 8'hFF;
      pend_q  <= 8'h00;
      drop_q  <= 8'h00;
      valid_q <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign pend_out  = pend_q & mask;
  assign irq_valid = valid_q;
  assign irq_code  = code_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl with a behavioural 8:3 priority encoder in the loop.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic [7:0] pend_out;
  logic [2:0] enc_code;
  logic       enc_v;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic       irq_ack;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  irq_pending_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .mask     (mask),
    .pend_out (pend_out),
    .enc_code (enc_code),
    .enc_v    (enc_v),
    .irq_valid(irq_valid),
    .irq_code (irq_code),
    .irq_ack  (irq_ack),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Highest set bit wins.
  always_comb begin
    enc_v    = |pend_out;
    enc_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_out[i]) enc_code = i[2:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 8'hFF; mask = 8'hFF; irq_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (pend_out !== 8'h00) begin
        n_fail++; $display("FAIL reset_pend cycle %0d: got %h exp 00", c, pend_out);
      end
      n_checks++;
      if (irq_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid cycle %0d: got %b exp 0", c, irq_valid);
      end
      n_checks++;
      if (drop_cnt !== 8'h00) begin
        n_fail++; $display("FAIL reset_drop cycle %0d: got %h exp 00", c, drop_cnt);
      end
    end
    req_in = 8'h00;
    tick();
  endtask

  task automatic test_single();
    req_in = 8'h08;
    tick();
    req_in = 8'h00;
    n_checks++;
    if (pend_out !== 8'h08 || irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pend: got pend %h valid %b exp 08 0", pend_out, irq_valid);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd3) begin
      n_fail++; $display("FAIL single_valid: got valid %b code %0d exp 1 3", irq_valid, irq_code);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_checks++;
    if (pend_out !== 8'h00 || irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: got pend %h valid %b exp 00 0", pend_out, irq_valid);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got valid %b exp 0", irq_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_code [3];
    logic [7:0] exp_pend [3];
    exp_code[0] = 3'd7; exp_code[1] = 3'd5; exp_code[2] = 3'd3;
    exp_pend[0] = 8'h28; exp_pend[1] = 8'h08; exp_pend[2] = 8'h00;
    req_in = 8'hA8;
    tick();
    req_in  = 8'h00;
    irq_ack = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      n_checks++;
      if (irq_valid !== 1'b1 || irq_code !== exp_code[n]) begin
        n_fail++;
        $display("FAIL b2b_serve %0d: got valid %b code %0d exp 1 %0d", n, irq_valid, irq_code,
                 exp_code[n]);
      end
      tick();
      n_checks++;
      if (irq_valid !== 1'b0 || pend_out !== exp_pend[n]) begin
        n_fail++;
        $display("FAIL b2b_gap %0d: got valid %b pend %h exp 0 %h", n, irq_valid, pend_out,
                 exp_pend[n]);
      end
    end
    irq_ack = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    mask   = 8'h08;
    req_in = 8'h48;
    tick();
    req_in = 8'h00;
    n_checks++;
    if (pend_out !== 8'h08) begin
      n_fail++; $display("FAIL mask_pend: got %h exp 08", pend_out);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd3) begin
      n_fail++; $display("FAIL mask_serve3: got valid %b code %0d exp 1 3", irq_valid, irq_code);
    end
    mask = 8'h00;
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd3) begin
      n_fail++; $display("FAIL mask_hold: got valid %b code %0d exp 1 3", irq_valid, irq_code);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    n_checks++;
    if (irq_valid !== 1'b0 || pend_out !== 8'h00) begin
      n_fail++; $display("FAIL mask_hidden: got valid %b pend %h exp 0 00", irq_valid, pend_out);
    end
    mask = 8'hFF;
    #1;
    n_checks++;
    if (pend_out !== 8'h40) begin
      n_fail++; $display("FAIL mask_expose: got %h exp 40", pend_out);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd6) begin
      n_fail++; $display("FAIL mask_serve6: got valid %b code %0d exp 1 6", irq_valid, irq_code);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_checks++;
    if (irq_valid !== 1'b0 || pend_out !== 8'h00) begin
      n_fail++; $display("FAIL mask_done: got valid %b pend %h exp 0 00", irq_valid, pend_out);
    end
  endtask

  task automatic test_drop();
    req_in = 8'h02;
    tick();
    req_in = 8'h00;
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd1 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL drop_serve: got valid %b code %0d drop %0d exp 1 1 0", irq_valid, irq_code,
               drop_cnt);
    end
    req_in = 8'h02;
    tick();
    req_in = 8'h00;
    n_checks++;
    if (drop_cnt !== 8'd1 || irq_code !== 3'd1) begin
      n_fail++; $display("FAIL drop_first: got drop %0d code %0d exp 1 1", drop_cnt, irq_code);
    end
    tick();
    // Rise on bit 1 in the ack cycle of code 1.
    req_in  = 8'h02;
    irq_ack = 1'b1;
    tick();
    req_in  = 8'h00;
    irq_ack = 1'b0;
    n_checks++;
    if (pend_out !== 8'h02 || irq_valid !== 1'b0 || drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL set_wins: got pend %h valid %b drop %0d exp 02 0 2", pend_out, irq_valid,
               drop_cnt);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd1) begin
      n_fail++; $display("FAIL set_wins_reserve: got valid %b code %0d exp 1 1", irq_valid,
                         irq_code);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_checks++;
    if (pend_out !== 8'h00 || irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_clear: got pend %h valid %b exp 00 0", pend_out, irq_valid);
    end
    // Park bit 0 behind a zero mask and keep re-pulsing it.
    mask   = 8'h00;
    req_in = 8'h01;
    tick();
    req_in = 8'h00;
    tick();
    for (int j = 1; j <= 300; j++) begin
      req_in = 8'h01;
      tick();
      req_in = 8'h00;
      tick();
      if (j == 252 || j == 253 || j == 300) begin
        n_checks++;
        if (drop_cnt !== ((j + 2 > 255) ? 8'd255 : 8'(j + 2))) begin
          n_fail++; $display("FAIL drop_sat after %0d: got %0d", j, drop_cnt);
        end
      end
    end
    n_checks++;
    if (pend_out !== 8'h00 || irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_masked: got pend %h valid %b exp 00 0", pend_out, irq_valid);
    end
  endtask

  task automatic test_reset_mid();
    mask = 8'hFF;
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_pre: got valid %b code %0d exp 1 0", irq_valid, irq_code);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (irq_valid !== 1'b0 || pend_out !== 8'h00 || drop_cnt !== 8'd0 || irq_code !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got valid %b pend %h drop %0d code %0d exp 0 00 0 0",
               irq_valid, pend_out, drop_cnt, irq_code);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    n_checks++;
    if (irq_valid !== 1'b0 || pend_out !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_ack: got valid %b pend %h exp 0 00", irq_valid, pend_out);
    end
    req_in = 8'h04;
    tick();
    req_in = 8'h00;
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_code !== 3'd2) begin
      n_fail++; $display("FAIL rstmid_resume: got valid %b code %0d exp 1 2", irq_valid, irq_code);
    end
  endtask

  initial begin
    rst = 1'b1; req_in = 8'h00; mask = 8'hFF; irq_ack = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
